uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter. It is the sending end of the link serviced by the existing UART receiver.
- Accepts a byte from the host through a single-entry transmit data register (TDR) and moves it into a transmit shift register (TSR).
- Serialises the TSR onto TxD as 8N1 frames: start bit, 8 data bits LSB first, stop bit. Optional parity per the feature below.
- Double buffering lets the host preload the next byte while the current frame is shifting, so frames go out back-to-back.

Parameters:
- BIT_TIME, 2600: clock cycles per bit (9600 baud at 25 MHz). Legal range 2..4095.
- CNT_W, 12: width of the baud counter. Must satisfy 2^CNT_W > BIT_TIME.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- clr  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to transmit; sampled only in the cycle `load` is accepted.
- load  in  1  write strobe; accepted only when tdre=1.
- TxD  out  1  serial line; idle high.
- tdre  out  1  TDR empty; host may load when high.
- busy  out  1  high while a frame is on the line (state != mark).

Behaviour:
- Reset: clr sampled high at a rising edge forces, at that edge:
  - state=mark, TxD=1, tdre=1, busy=0.
  - TDR, TSR, baud counter and bit counter all 0.
  - clr overrides every other input, including mid-frame: TxD returns to 1 after that edge and the partial frame is abandoned.
- TDR write: load=1 and tdre=1 at edge N → TDR<=tx_data and tdre=0 after edge N.
  - load while tdre=0 is ignored. TDR is unchanged and no error is flagged.
- TDR→TSR transfer: in state mark with tdre=0 at edge M:
  - TSR<=TDR, tdre<=1, bit counter<=0, baud counter<=0, state<=start.
  - TxD=0 after edge M.
- Idle latency: load at edge N → transfer at edge N+1 → TxD falls after edge N+1.
- A load and a transfer can never coincide: a transfer requires tdre=0, which blocks the load.
- FSM states: mark, start, data, parity (only with the optional feature), stop.
- Bit timing: every state except mark holds TxD for exactly BIT_TIME cycles.
  - The baud counter counts 0..BIT_TIME-1 and clears at BIT_TIME-1.
  - The state advances on that same edge.
- start: TxD=0; then go to data.
- data: TxD=TSR[0].
  - At the end of each bit: TSR shifts right one place (zero fill) and the bit counter increments.
  - After the bit counter reaches 8, go to parity (feature enabled) or stop.
- stop: TxD=1 for BIT_TIME cycles. At the end of the stop bit:
  - if tdre=0, transfer immediately (same edge rules as above) and go to start, so the next start bit follows with no idle cycle;
  - otherwise go to mark.
- busy = (state != mark), registered alongside state.
- Frame lengths:
  - 10*BIT_TIME cycles with the feature off.
  - 11*BIT_TIME cycles with the feature on.
- Counter rules: the counter width is CNT_W and must never wrap. The terminal compare is equality with BIT_TIME-1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds parameter ODD_PARITY, default 0.
  - Parity state sits between data and stop and drives TxD = (^byte) ^ ODD_PARITY for BIT_TIME cycles.
  - The parity source is the byte captured into the TSR at transfer time, held in a separate parity register.
- Undefined:
  - No parity state, register or parameter is present.
  - data goes straight to stop.

Test Plan (BIT_TIME=4 unless noted):
- Reset idle → after clr, TxD=1, tdre=1, busy=0 held for 20 cycles with load=0.
- Single byte: load 8'h55 with tdre=1 at edge 0 →
  - tdre=0 after edge 0, TxD falls after edge 1, tdre=1 after edge 1;
  - TxD carries 0,1,0,1,0,1,0,1,0,1, each bit exactly 4 cycles;
  - busy drops after 40 cycles of frame.
- Back-to-back: load 8'hA3, then load 8'h0F as soon as tdre=1 →
  - second start bit begins the cycle after the first frame's last stop cycle, with no idle gap;
  - line reads LSB-first 8'hA3 then 8'h0F.
- Ignored load: load 8'h11 (tdre=0) while 8'h22 is buffered and 8'h33 is shifting → frames 8'h33 then 8'h22 go out; 8'h11 never appears.
- Reset mid-frame: assert clr during data bit 3 of 8'hF0 → TxD=1, tdre=1, busy=0 after that edge; a next load of 8'h81 transmits correctly.
- Parity, UART_TX_PARITY_EN with ODD_PARITY=0 → 8'h07 gives parity bit 1 and 8'h03 gives 0; each frame is 44 cycles.

Source files
------------

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_if
// Description : Host-side bus of the UART transmitter (byte load + line/status)
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       load;
  logic       TxD;
  logic       tdre;
  logic       busy;

  modport master (
    output tx_data,
    output load,
    input  TxD,
    input  tdre,
    input  busy
  );

  modport slave (
    input  tx_data,
    input  load,
    output TxD,
    output tdre,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Double-buffered 8N1 UART transmitter (TDR -> TSR -> TxD).
//               Define UART_TX_PARITY_EN to insert a parity bit (ODD_PARITY).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int BIT_TIME = 2600,
  parameter int CNT_W    = 12
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit ODD_PARITY = 1'b0
`endif
) (
  input  wire         clk,
  input  wire         clr,
  uart_tx_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_MARK  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } state_t;

  localparam logic [CNT_W-1:0] c_BAUD_LAST = CNT_W'(BIT_TIME - 1);
  localparam logic [3:0]       c_LAST_BIT  = 4'd7;

  state_t           r_state, w_state_nx;
  logic [7:0]       r_tdr, w_tdr_nx;
  logic [7:0]       r_tsr, w_tsr_nx;
  logic [CNT_W-1:0] r_baud, w_baud_nx;
  logic [3:0]       r_bitcnt, w_bitcnt_nx;
  logic             r_tdre, w_tdre_nx;
  logic             r_txd, w_txd_nx;
  logic             r_busy, w_busy_nx;
  logic             w_bit_end;
  logic             w_xfer;
`ifdef UART_TX_PARITY_EN
  logic             r_par, w_par_nx;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= ST_MARK;
      r_tdr    <= 8'h00;
      r_tsr    <= 8'h00;
      r_baud   <= '0;
      r_bitcnt <= 4'd0;
      r_tdre   <= 1'b1;
      r_txd    <= 1'b1;
      r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nx;
      r_tdr    <= w_tdr_nx;
      r_tsr    <= w_tsr_nx;
      r_baud   <= w_baud_nx;
      r_bitcnt <= w_bitcnt_nx;
      r_tdre   <= w_tdre_nx;
      r_txd    <= w_txd_nx;
      r_busy   <= w_busy_nx;
`ifdef UART_TX_PARITY_EN
      r_par    <= w_par_nx;
`endif
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_tdr_nx    = r_tdr;
    w_tsr_nx    = r_tsr;
    w_baud_nx   = r_baud;
    w_bitcnt_nx = r_bitcnt;
    w_tdre_nx   = r_tdre;
    w_xfer      = 1'b0;
    w_bit_end   = (r_baud == c_BAUD_LAST);
`ifdef UART_TX_PARITY_EN
    w_par_nx    = r_par;
`endif

    // A load needs tdre=1 and a transfer needs tdre=0, so they never collide.
    if (bus.load && r_tdre) begin
      w_tdr_nx  = bus.tx_data;
      w_tdre_nx = 1'b0;
    end

    if (r_state != ST_MARK) begin
      w_baud_nx = w_bit_end ? '0 : r_baud + 1'b1;
    end

    case (r_state)
      ST_MARK: begin
        w_xfer = !r_tdre;
      end
      ST_START: begin
        if (w_bit_end) w_state_nx = ST_DATA;
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_tsr_nx    = {1'b0, r_tsr[7:1]};
          w_bitcnt_nx = r_bitcnt + 4'd1;
          if (r_bitcnt == c_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            w_state_nx = ST_PARITY;
`else
            w_state_nx = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) w_state_nx = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (w_bit_end) begin
          w_state_nx = ST_MARK;
          w_xfer     = !r_tdre;
        end
      end
      default: begin
        w_state_nx = ST_MARK;
      end
    endcase

    if (w_xfer) begin
      w_tsr_nx    = r_tdr;
      w_tdre_nx   = 1'b1;
      w_bitcnt_nx = 4'd0;
      w_baud_nx   = '0;
      w_state_nx  = ST_START;
`ifdef UART_TX_PARITY_EN
      w_par_nx    = (^r_tdr) ^ ODD_PARITY;
`endif
    end

    // Line level is registered from the next state to keep TxD glitch-free.
    case (w_state_nx)
      ST_START:  w_txd_nx = 1'b0;
      ST_DATA:   w_txd_nx = w_tsr_nx[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_txd_nx = w_par_nx;
`endif
      default:   w_txd_nx = 1'b1;
    endcase
    w_busy_nx = (w_state_nx != ST_MARK);
  end

  assign bus.TxD  = r_txd;
  assign bus.tdre = r_tdre;
  assign bus.busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx against a line-level frame model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;
  localparam int BT = 4;
`ifdef UART_TX_PARITY_EN
  localparam int  FRAME = 11 * BT;
  localparam bit  ODD   = 1'b0;
`else
  localparam int  FRAME = 10 * BT;
`endif

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic got_txd [0:511];
  logic got_busy[0:511];
  int   got_n;
  logic exp_txd [0:511];
  logic exp_busy[0:511];
  int   exp_n;

  uart_tx_if u_if();

  uart_tx #(
    .BIT_TIME(BT),
    .CNT_W(12)
`ifdef UART_TX_PARITY_EN
    ,
    .ODD_PARITY(ODD)
`endif
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  // Advance one edge, then record the line as seen just after it.
  task automatic step_rec();
    @(posedge clk);
    #1;
    got_txd[got_n]  = u_if.TxD;
    got_busy[got_n] = u_if.busy;
    got_n++;
  endtask

  task automatic exp_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_txd[exp_n] = 1'b1; exp_busy[exp_n] = 1'b0; exp_n++;
    end
  endtask

  // Reference frame: start, LSB-first data, optional parity, stop; BT cycles each.
  task automatic exp_frame(input logic [7:0] b);
    logic bits[$];
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(b[k]);
`ifdef UART_TX_PARITY_EN
    bits.push_back((^b) ^ ODD);
`endif
    bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int c = 0; c < BT; c++) begin
        exp_txd[exp_n] = bits[k]; exp_busy[exp_n] = 1'b1; exp_n++;
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; u_if.load = 1'b0; u_if.tx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1; clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({u_if.TxD, u_if.tdre, u_if.busy} !== 3'b110) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got TxD/tdre/busy=%b expected 110", i,
                 {u_if.TxD, u_if.tdre, u_if.busy});
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] b;
    for (int t = 0; t < 5; t++) begin
      b = (t == 0) ? 8'h55 : 8'($urandom_range(0, 255));
      got_n = 0; exp_n = 0;
      u_if.tx_data = b; u_if.load = 1'b1;
      step_rec();
      checks++;
      if (u_if.tdre !== 1'b0) begin
        errors++; $display("FAIL single_tdre_load byte=%h got %b expected 0", b, u_if.tdre);
      end
      u_if.load = 1'b0; u_if.tx_data = 8'h00;
      step_rec();
      checks++;
      if (u_if.tdre !== 1'b1) begin
        errors++; $display("FAIL single_tdre_xfer byte=%h got %b expected 1", b, u_if.tdre);
      end
      repeat (FRAME + 1) step_rec();
      exp_idle(1); exp_frame(b); exp_idle(2);
      for (int i = 0; i < exp_n; i++) begin
        checks++;
        if (got_txd[i] !== exp_txd[i] || got_busy[i] !== exp_busy[i]) begin
          errors++;
          $display("FAIL single_line byte=%h cyc=%0d got TxD=%b busy=%b expected TxD=%b busy=%b",
                   b, i, got_txd[i], got_busy[i], exp_txd[i], exp_busy[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    for (int t = 0; t < 4; t++) begin
      a = (t == 0) ? 8'hA3 : 8'($urandom_range(0, 255));
      b = (t == 0) ? 8'h0F : 8'($urandom_range(0, 255));
      got_n = 0; exp_n = 0;
      u_if.tx_data = a; u_if.load = 1'b1;
      step_rec();
      u_if.load = 1'b0;
      step_rec();
      checks++;
      if (u_if.tdre !== 1'b1) begin
        errors++; $display("FAIL b2b_tdre pair=%0d got %b expected 1", t, u_if.tdre);
      end
      u_if.tx_data = b; u_if.load = 1'b1;
      step_rec();
      u_if.load = 1'b0; u_if.tx_data = 8'h00;
      repeat (2 * FRAME) step_rec();
      exp_idle(1); exp_frame(a); exp_frame(b); exp_idle(2);
      for (int i = 0; i < exp_n; i++) begin
        checks++;
        if (got_txd[i] !== exp_txd[i] || got_busy[i] !== exp_busy[i]) begin
          errors++;
          $display("FAIL b2b_line %h,%h cyc=%0d got TxD=%b busy=%b expected TxD=%b busy=%b",
                   a, b, i, got_txd[i], got_busy[i], exp_txd[i], exp_busy[i]);
        end
      end
    end
  endtask

  task automatic test_ignored_load();
    got_n = 0; exp_n = 0;
    u_if.tx_data = 8'h33; u_if.load = 1'b1;
    step_rec();
    u_if.load = 1'b0;
    step_rec();
    u_if.tx_data = 8'h22; u_if.load = 1'b1;
    step_rec();
    checks++;
    if (u_if.tdre !== 1'b0) begin
      errors++; $display("FAIL ignored_tdre got %b expected 0", u_if.tdre);
    end
    u_if.tx_data = 8'h11; u_if.load = 1'b1;
    step_rec();
    u_if.load = 1'b0; u_if.tx_data = 8'h00;
    repeat (2 * FRAME - 1) step_rec();
    exp_idle(1); exp_frame(8'h33); exp_frame(8'h22); exp_idle(2);
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (got_txd[i] !== exp_txd[i] || got_busy[i] !== exp_busy[i]) begin
        errors++;
        $display("FAIL ignored_line cyc=%0d got TxD=%b busy=%b expected TxD=%b busy=%b",
                 i, got_txd[i], got_busy[i], exp_txd[i], exp_busy[i]);
      end
    end
    checks++;
    if (u_if.tdre !== 1'b1) begin
      errors++; $display("FAIL ignored_final_tdre got %b expected 1", u_if.tdre);
    end
  endtask

  task automatic test_reset_mid_frame();
    got_n = 0; exp_n = 0;
    u_if.tx_data = 8'hF0; u_if.load = 1'b1;
    step_rec();
    u_if.load = 1'b0;
    step_rec();
    // Land one cycle into data bit 3 (start + 3 data bits after the transfer edge).
    repeat (4 * BT + 1) step_rec();
    checks++;
    if ({u_if.TxD, u_if.busy} !== 2'b01) begin
      errors++; $display("FAIL midframe_bit3 got TxD/busy=%b expected 01", {u_if.TxD, u_if.busy});
    end
    clr = 1'b1;
    step_rec();
    clr = 1'b0;
    checks++;
    if ({u_if.TxD, u_if.tdre, u_if.busy} !== 3'b110) begin
      errors++; $display("FAIL midframe_clr got TxD/tdre/busy=%b expected 110",
                         {u_if.TxD, u_if.tdre, u_if.busy});
    end
    repeat (3) step_rec();
    checks++;
    if ({u_if.TxD, u_if.tdre, u_if.busy} !== 3'b110) begin
      errors++; $display("FAIL midframe_idle got TxD/tdre/busy=%b expected 110",
                         {u_if.TxD, u_if.tdre, u_if.busy});
    end
    got_n = 0; exp_n = 0;
    u_if.tx_data = 8'h81; u_if.load = 1'b1;
    step_rec();
    u_if.load = 1'b0; u_if.tx_data = 8'h00;
    repeat (FRAME + 2) step_rec();
    exp_idle(1); exp_frame(8'h81); exp_idle(2);
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (got_txd[i] !== exp_txd[i] || got_busy[i] !== exp_busy[i]) begin
        errors++;
        $display("FAIL after_clr_line cyc=%0d got TxD=%b busy=%b expected TxD=%b busy=%b",
                 i, got_txd[i], got_busy[i], exp_txd[i], exp_busy[i]);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] b;
    logic       p_exp;
    int         busy_cnt;
    for (int t = 0; t < 2; t++) begin
      b     = (t == 0) ? 8'h07 : 8'h03;
      p_exp = (t == 0) ? 1'b1 : 1'b0;
      got_n = 0;
      u_if.tx_data = b; u_if.load = 1'b1;
      step_rec();
      u_if.load = 1'b0;
      repeat (FRAME + 2) step_rec();
      // Parity slot begins after start + 8 data bits, from the transfer sample (index 1).
      for (int c = 0; c < BT; c++) begin
        checks++;
        if (got_txd[1 + 9 * BT + c] !== p_exp) begin
          errors++; $display("FAIL parity_bit byte=%h cyc=%0d got %b expected %b",
                             b, c, got_txd[1 + 9 * BT + c], p_exp);
        end
      end
      busy_cnt = 0;
      for (int i = 0; i < got_n; i++) busy_cnt += int'(got_busy[i]);
      checks++;
      if (busy_cnt != 44) begin
        errors++; $display("FAIL parity_frame_len byte=%h got %0d expected 44", b, busy_cnt);
      end
    end
  endtask
`endif

  initial begin
    u_if.load = 1'b0;
    u_if.tx_data = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_ignored_load();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
